// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Rebuilds LSB-first framed words from the 1-bit serial stream of the
// upstream register stage. Frame: start(0), WIDTH data bits, optional even
// parity bit, stop(1). The line idles high. Good words are delivered with a
// one-cycle data_valid strobe. Parity and framing faults each raise a
// one-cycle flag, and the faulty word is discarded.
// Every output is registered. All decisions use the synchronized copy of din.

module serial_frame_rx #(
    parameter int WIDTH      = 8,   // data bits per frame (1..16)
    parameter int BIT_CYCLES = 4,   // clk cycles per serial bit (>=4)
    parameter int PARITY_EN  = 1    // 1: even parity bit present and checked
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(WIDTH + 1);

    // START re-samples half a bit in. Every later state samples one full bit
    // after the previous sample, so it lands on mid-bit.
    localparam logic [CW-1:0] HALF_LAST  = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_DATA  = BW'(WIDTH - 1);
    localparam bit            HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Synchronizer and FSM state
    logic             sync1_q;
    logic             din_s_q;
    state_t           state_q,  state_d;
    logic [CW-1:0]    cyc_q,    cyc_d;
    logic [BW-1:0]    bit_q,    bit_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic             par_q,    par_d;

    // Registered outputs
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q,    valid_d;
    logic             perr_q,     perr_d;
    logic             ferr_q,     ferr_d;
    logic             busy_q,     busy_d;

    // Shift register after taking the current sample. New bits enter at the
    // top, so the first bit received ends up in bit 0.
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_shift_one
            assign shifted = din_s_q;
        end else begin : g_shift_many
            assign shifted = {din_s_q, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // The word is good when parity is disabled, or when the data bits and
    // the parity bit together hold an even number of ones.
    logic parity_ok;
    assign parity_ok = !HAS_PARITY || ((^shreg_q) == par_q);

    // Two-flop synchronizer on the serial line. It resets to the idle level
    // so that a reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            din_s_q <= 1'b1;
        end else begin
            sync1_q <= din;
            din_s_q <= sync1_q;
        end
    end

    // FSM, counters, data path and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic and frame decoding. The result pulses default low, so
    // each one lasts a single cycle.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!din_s_q) begin
                    state_d = START;
                    cyc_d   = '0;
                end
            end

            START: begin
                if (cyc_q == HALF_LAST) begin
                    cyc_d = '0;
                    if (!din_s_q) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        // The start bit did not last half a bit, so treat it
                        // as a glitch and drop it without raising a flag.
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            DATA: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    shreg_d = shifted;
                    if (bit_q == LAST_DATA) begin
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            PARITY: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    par_d   = din_s_q;
                    state_d = STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            STOP: begin
                // Return to IDLE at the stop mid-bit. A start bit that
                // directly follows the stop bit is then still caught.
                if (cyc_q == BIT_LAST) begin
                    cyc_d = '0;
                    if (!din_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else if (parity_ok) begin
                        data_out_d = shreg_q;
                        valid_d    = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            BREAK: begin
                // A low line here is still part of the broken frame. Wait
                // until the line is released before looking for a new start.
                if (din_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Drives serial frames into serial_frame_rx: directed cases first, then
// randomized frames. For each frame the bench predicts the outcome and its
// arrival cycle from the frame contents alone, and queues that prediction.
// An independent monitor compares every DUT pulse against the queue.

module tb_serial_frame_rx;

    localparam int WIDTH = 8;
    localparam int BC    = 4;
    localparam int PEN   = 1;
    // Cycles from the first low start-bit cycle to the result pulse.
    localparam int LAT   = 2 + BC / 2 + (WIDTH + PEN + 1) * BC;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_PERR  = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b100;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             din   = 1'b1;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    serial_frame_rx #(
        .WIDTH      (WIDTH),
        .BIT_CYCLES (BC),
        .PARITY_EN  (PEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]       kind;
        logic [WIDTH-1:0] data;
        int               when;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] last_good = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest prediction in kind, word
    // and cycle. A prediction whose cycle passes without a pulse is a miss.
    logic [2:0] mon_kind;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_kind = {frame_err, parity_err, data_valid};
            if (exp_q.size() > 0 && cyc > exp_q[0].when) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event actual=none required=kind %0b at cycle %0d", mon_e.kind, mon_e.when);
            end
            if (mon_kind != 3'b000) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=kind %0b data %0h required=none (cycle %0d)", mon_kind, data_out, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                    check("event_data", 32'(data_out), 32'(mon_e.data));
                    check("event_cycle", 32'(cyc), 32'(mon_e.when));
                    $display("event kind=%0b data=%02h cycle=%0d", mon_kind, data_out, cyc);
                end
            end
        end
    end

    task automatic hold(input logic b, input int n);
        din = b;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame starting at the current negedge and queues the
    // predicted result. The result lands LAT cycles after the first low
    // cycle, and the monitor sees it one count later.
    task automatic send_frame(input logic [WIDTH-1:0] d, input bit bad_par,
                              input bit bad_stop, input int extra_low_bits);
        exp_t e;
        logic p;
        p      = (($countones(d) % 2) == 1) ^ bad_par;
        e.when = cyc + 1 + LAT;
        if (bad_stop) begin
            e.kind = K_FERR;
            e.data = last_good;
        end else if (bad_par) begin
            e.kind = K_PERR;
            e.data = last_good;
        end else begin
            e.kind    = K_VALID;
            e.data    = d;
            last_good = d;
        end
        exp_q.push_back(e);
        hold(1'b0, BC);
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < WIDTH; i++) hold(d[i], BC);
        if (PEN != 0) hold(p, BC);
        hold(!bad_stop, BC);
        if (bad_stop) hold(1'b0, extra_low_bits * BC);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit saw_busy;
        logic [WIDTH-1:0] rd;
        int r;

        // Reset state
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 2 * BC);

        // Good frame, then the same frame with a wrong parity bit
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        hold(1'b1, BC);
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        hold(1'b1, 2 * BC);

        // A one-cycle low glitch while idle is rejected
        saw_busy = 1'b0;
        din = 1'b0;
        @(negedge clk);
        din = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_data_held", 32'(data_out), 32'(last_good));

        // Framing error with the line held low, then a normal frame
        send_frame(8'h3C, 1'b0, 1'b1, 5);
        check("break_busy", 32'(busy), 32'd1);
        hold(1'b1, 2 * BC);
        send_frame(8'h3C, 1'b0, 1'b0, 0);

        // Two frames back to back with no idle gap
        send_frame(8'h01, 1'b0, 1'b0, 0);
        send_frame(8'hFE, 1'b0, 1'b0, 0);
        hold(1'b1, 2 * BC);
        drain();

        // Reset in the middle of the data bits
        hold(1'b0, BC);
        hold(1'b1, BC);
        hold(1'b0, 2 * BC);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        last_good = '0;
        hold(1'b1, 3 * BC);
        check("midrst_quiet", 32'(data_out), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        hold(1'b1, BC);

        // Randomized frames with random faults and gaps
        for (int k = 0; k < 24; k++) begin
            rd = WIDTH'($urandom);
            r  = $urandom_range(0, 5);
            if (r == 0) begin
                send_frame(rd, 1'b0, 1'b1, $urandom_range(0, 3));
                hold(1'b1, $urandom_range(2, 6));
            end else begin
                send_frame(rd, (r == 1), 1'b0, 0);
                hold(1'b1, $urandom_range(0, 6));
            end
        end
        hold(1'b1, 2 * BC);
        drain();
        check("final_data_out", 32'(data_out), 32'(last_good));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
